// File: rtl/video_frame_monitor_pkg.sv
// Shared definitions for the raster/CRC frame monitor: FSM states, CRC constants and
// saturating counter helpers.
package video_frame_monitor_pkg;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StPrime  = 2'd1,
    StLock1  = 2'd2,
    StLocked = 2'd3
  } mon_state_e;

  localparam logic [15:0] CrcPoly = 16'h1021;
  localparam logic [15:0] CrcInit = 16'hFFFF;

  // Counters stick at all-ones instead of wrapping so overlong lines stay visible.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

endpackage

// File: rtl/crc16_3bit.sv
// Combinational CRC-16 (poly 0x1021) advance by one 3-bit pixel, data MSB first.
module crc16_3bit
  import video_frame_monitor_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [2:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_tmp;

  // Three serial shift steps unrolled: r, then g, then b.
  always_comb begin
    crc_tmp = crc_i;
    for (int i = 2; i >= 0; i--) begin
      if (crc_tmp[15] ^ data_i[i]) begin
        crc_tmp = {crc_tmp[14:0], 1'b0} ^ CrcPoly;
      end else begin
        crc_tmp = {crc_tmp[14:0], 1'b0};
      end
    end
    crc_o = crc_tmp;
  end

endmodule

// File: rtl/video_frame_monitor.sv
// Raster timing monitor: measures line/frame timing and active area, signs the active
// pixels with CRC-16 and reports once per frame with lock tracking and sticky errors.
module video_frame_monitor
  import video_frame_monitor_pkg::*;
#(
  parameter int unsigned H_TOTAL  = 309,
  parameter int unsigned V_TOTAL  = 262,
  parameter int unsigned H_ACTIVE = 256,
  parameter int unsigned V_ACTIVE = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        display_on,
  input  logic [2:0]  rgb,
  output logic        frame_done,
  output logic [9:0]  h_total,
  output logic [9:0]  line_total,
  output logic [8:0]  active_pixels,
  output logic [8:0]  active_lines,
  output logic [15:0] signature,
  output logic        locked,
  output logic        err_h,
  output logic        err_v,
  output logic        err_act
);

  localparam logic [9:0] HTotal  = 10'(H_TOTAL);
  localparam logic [9:0] VTotal  = 10'(V_TOTAL);
  localparam logic [8:0] HActive = 9'(H_ACTIVE);
  localparam logic [8:0] VActive = 9'(V_ACTIVE);

  // Input stage
  logic       hsync_d1_q, hsync_d2_q, vsync_d1_q, vsync_d2_q, de_d1_q;
  logic [2:0] rgb_d1_q;
  logic       hs_rise, vs_rise;

  // Measurement counters
  logic [9:0]  hclk_q, vcnt_q;
  logic [8:0]  pix_q, alines_q;
  logic [15:0] crc_q;
  logic        fh_bad_q, fa_bad_q;

  // Reported results
  logic        done_q;
  logic [9:0]  h_total_q, line_total_q;
  logic [8:0]  act_pix_q, act_lines_q;
  logic [15:0] sig_q;
  logic        err_h_q, err_v_q, err_act_q;

  // FSM
  mon_state_e state_q, state_d;
  logic       miss_q, miss_d;
  logic       report_en;

  // Close-of-line / close-of-frame values, including the current cycle's pixel
  logic [15:0] crc_step, crc_close;
  logic [9:0]  h_close, lines_close;
  logic [8:0]  pix_close, alines_close;
  logic        line_act, line_h_bad, line_a_bad;
  logic        line_fh_bad, line_fa_bad;
  logic        frame_a_bad, frame_v_bad, frame_good;

  // Register raw inputs once, syncs twice for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_d1_q <= 1'b0;
      hsync_d2_q <= 1'b0;
      vsync_d1_q <= 1'b0;
      vsync_d2_q <= 1'b0;
      de_d1_q    <= 1'b0;
      rgb_d1_q   <= 3'b000;
    end else begin
      hsync_d1_q <= hsync;
      hsync_d2_q <= hsync_d1_q;
      vsync_d1_q <= vsync;
      vsync_d2_q <= vsync_d1_q;
      de_d1_q    <= display_on;
      rgb_d1_q   <= rgb;
    end
  end

  assign hs_rise = hsync_d1_q & ~hsync_d2_q;
  assign vs_rise = vsync_d1_q & ~vsync_d2_q;

  crc16_3bit u_crc (
    .crc_i  (crc_q),
    .data_i (rgb_d1_q),
    .crc_o  (crc_step)
  );

  // Values a closing line/frame would report; a coincident hsync rise closes its line
  // into the frame that vsync is ending.
  always_comb begin
    h_close      = sat_inc10(hclk_q);
    pix_close    = de_d1_q ? sat_inc9(pix_q) : pix_q;
    crc_close    = de_d1_q ? crc_step : crc_q;
    line_act     = (pix_close != 9'd0);
    line_h_bad   = (h_close != HTotal);
    line_a_bad   = line_act && (pix_close != HActive);
    line_fh_bad  = fh_bad_q | (hs_rise & line_h_bad);
    line_fa_bad  = fa_bad_q | (hs_rise & line_a_bad);
    lines_close  = hs_rise ? sat_inc10(vcnt_q) : vcnt_q;
    alines_close = (hs_rise && line_act) ? sat_inc9(alines_q) : alines_q;
    frame_v_bad  = (lines_close != VTotal);
    frame_a_bad  = line_fa_bad | (alines_close != VActive);
    frame_good   = ~(line_fh_bad | frame_a_bad | frame_v_bad);
  end

  // Per-line and per-frame counters; vsync rise restarts the frame accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      hclk_q   <= '0;
      pix_q    <= '0;
      vcnt_q   <= '0;
      alines_q <= '0;
      crc_q    <= CrcInit;
      fh_bad_q <= 1'b0;
      fa_bad_q <= 1'b0;
    end else begin
      hclk_q   <= hs_rise ? 10'd0 : sat_inc10(hclk_q);
      pix_q    <= hs_rise ? 9'd0 : pix_close;
      vcnt_q   <= vs_rise ? 10'd0 : lines_close;
      alines_q <= vs_rise ? 9'd0 : alines_close;
      crc_q    <= vs_rise ? CrcInit : crc_close;
      fh_bad_q <= vs_rise ? 1'b0 : line_fh_bad;
      fa_bad_q <= vs_rise ? 1'b0 : line_fa_bad;
    end
  end

  // Latch line results on hsync rise, frame results plus frame_done on vsync rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q       <= 1'b0;
      h_total_q    <= '0;
      act_pix_q    <= '0;
      line_total_q <= '0;
      act_lines_q  <= '0;
      sig_q        <= '0;
    end else begin
      done_q <= vs_rise & report_en;
      if (hs_rise) begin
        h_total_q <= h_close;
        if (line_act) begin
          act_pix_q <= pix_close;
        end
      end
      if (vs_rise && report_en) begin
        line_total_q <= lines_close;
        act_lines_q  <= alines_close;
        sig_q        <= crc_close;
      end
    end
  end

  // Sticky error flags, only armed once a frame is being measured.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_h_q   <= 1'b0;
      err_v_q   <= 1'b0;
      err_act_q <= 1'b0;
    end else if (report_en) begin
      err_h_q   <= err_h_q | (hs_rise & line_h_bad);
      err_v_q   <= err_v_q | (vs_rise & frame_v_bad);
      err_act_q <= err_act_q | (hs_rise & line_a_bad) |
                   (vs_rise & (alines_close != VActive));
    end
  end

  // FSM state register; miss_q remembers one bad frame while locked.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StSearch;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
    end
  end

  // FSM next state, evaluated once per vsync rise.
  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    if (vs_rise) begin
      case (state_q)
        StSearch: state_d = StPrime;
        StPrime:  state_d = frame_good ? StLock1 : StPrime;
        StLock1:  state_d = frame_good ? StLocked : StPrime;
        StLocked: begin
          if (frame_good) begin
            miss_d = 1'b0;
          end else if (miss_q) begin
            state_d = StSearch;
            miss_d  = 1'b0;
          end else begin
            miss_d = 1'b1;
          end
        end
        default: begin
          state_d = StSearch;
          miss_d  = 1'b0;
        end
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    report_en = (state_q != StSearch);
    locked    = (state_q == StLocked);
  end

  assign frame_done    = done_q;
  assign h_total       = h_total_q;
  assign line_total    = line_total_q;
  assign active_pixels = act_pix_q;
  assign active_lines  = act_lines_q;
  assign signature     = sig_q;
  assign err_h         = err_h_q;
  assign err_v         = err_v_q;
  assign err_act       = err_act_q;

endmodule

// File: tb/tb_video_frame_monitor.sv
// Scoreboard bench for video_frame_monitor on a scaled-down raster.
module tb_video_frame_monitor;

  localparam int HT       = 40;
  localparam int HA       = 24;
  localparam int VT       = 24;
  localparam int VA       = 16;
  localparam int HsW      = 4;
  localparam int DeStart  = 8;
  localparam int VsLine   = VA + 2;
  localparam int VsOffNom = 36;
  localparam int OddLine  = 10;
  localparam int RstLine  = 8;

  logic        clk = 1'b0;
  logic        reset, hsync, vsync, display_on;
  logic [2:0]  rgb;
  logic        frame_done, locked, err_h, err_v, err_act;
  logic [9:0]  h_total, line_total;
  logic [8:0]  active_pixels, active_lines;
  logic [15:0] signature;

  video_frame_monitor #(
    .H_TOTAL  (HT),
    .V_TOTAL  (VT),
    .H_ACTIVE (HA),
    .V_ACTIVE (VA)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .hsync         (hsync),
    .vsync         (vsync),
    .display_on    (display_on),
    .rgb           (rgb),
    .frame_done    (frame_done),
    .h_total       (h_total),
    .line_total    (line_total),
    .active_pixels (active_pixels),
    .active_lines  (active_lines),
    .signature     (signature),
    .locked        (locked),
    .err_h         (err_h),
    .err_v         (err_v),
    .err_act       (err_act)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    bit          exp_done;
    bit          exp_locked;
    logic [15:0] sig;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_e;

  int tests_run = 0;
  int tests_failed = 0;

  // Bench-side reference state
  int          m_state;  // 0 search, 1 prime, 2 lock1, 3 locked
  bit          m_miss;
  bit          m_bad;
  logic [15:0] m_crc;
  logic        prev_vs;
  logic [15:0] sig111;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [2:0] px);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 2; i >= 0; i--) begin
      fb = r[15] ^ px[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Reference FSM step at a vsync rise; fills the scoreboard entry.
  task automatic push_frame();
    sb_t e;
    bit  good;
    good       = !m_bad;
    e.due      = cyc + 2;
    e.exp_done = (m_state != 0);
    e.sig      = m_crc;
    case (m_state)
      0: m_state = 1;
      1: m_state = good ? 2 : 1;
      2: m_state = good ? 3 : 1;
      default: begin
        if (good) m_miss = 0;
        else if (m_miss) begin m_state = 0; m_miss = 0; end
        else m_miss = 1;
      end
    endcase
    e.exp_locked = (m_state == 3);
    sb_q.push_back(e);
    m_bad = 0;
    m_crc = 16'hFFFF;
  endtask

  // One generated frame; line OddLine has length len10, vsync rises at vs_off in VsLine.
  task automatic drive_frame(input int len10, input int vs_off, input int mode, input bit flip,
                             input bit do_reset);
    int         len;
    logic       vs, de;
    logic [2:0] px;
    for (int ln = 0; ln < VT; ln++) begin
      len = (ln == OddLine) ? len10 : HT;
      if (ln == OddLine && len10 != HT) m_bad = 1;
      for (int x = 0; x < len; x++) begin
        @(posedge clk); #1;
        if (do_reset && ln == RstLine && x == 1) begin
          check("reset_mid_outputs", 64'({frame_done, h_total, line_total, active_pixels,
                active_lines, signature, locked, err_h, err_v, err_act}), 64'd0);
          m_state = 0;
          m_miss  = 0;
          m_bad   = 0;
          m_crc   = 16'hFFFF;
        end
        if (ln == OddLine + 1 && x == 2 && len10 != HT) begin
          check("h_total_odd", 64'(h_total), 64'((len10 > 1023) ? 1023 : len10));
          check("err_h_odd", 64'(err_h), 64'd1);
          check("locked_odd", 64'(locked), 64'(m_state == 3));
        end
        reset = do_reset && ln == RstLine && x == 0;
        vs = (ln == VsLine && x >= vs_off) || (ln == VsLine + 1) ||
             (ln == VsLine + 2 && x < vs_off);
        de = (ln < VA) && (x >= DeStart) && (x < DeStart + HA);
        px = (mode == 1) ? 3'b111 : 3'((x + 3 * ln) >> 2);
        if (flip && ln == 5 && x == DeStart + 7) px = px ^ 3'b001;
        if (!de) px = 3'b000;
        hsync      = (x < HsW);
        vsync      = vs;
        display_on = de;
        rgb        = px;
        if (de) m_crc = crc_px(m_crc, px);
        if (vs && !prev_vs) push_frame();
        prev_vs = vs;
      end
    end
  endtask

  // Compare DUT reports against the scoreboard at the cycle each frame result is due.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      mon_e = sb_q.pop_front();
      check("frame_done", 64'(frame_done), 64'(mon_e.exp_done));
      if (mon_e.exp_done) begin
        check("h_total", 64'(h_total), 64'(HT));
        check("line_total", 64'(line_total), 64'(VT));
        check("active_pixels", 64'(active_pixels), 64'(HA));
        check("active_lines", 64'(active_lines), 64'(VA));
        check("signature", 64'(signature), 64'(mon_e.sig));
      end
      check("locked", 64'(locked), 64'(mon_e.exp_locked));
    end else if (frame_done) begin
      check("unexpected_done", 64'(frame_done), 64'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; hsync = 0; vsync = 0; display_on = 0; rgb = 3'b000;
    m_state = 0; m_miss = 0; m_bad = 0; m_crc = 16'hFFFF; prev_vs = 0; sig111 = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({frame_done, h_total, line_total, active_pixels, active_lines,
          signature, locked, err_h, err_v, err_act}), 64'd0);
    reset = 0;

    // Nominal frames: first rise primes, lock after the third.
    for (int i = 0; i < 4; i++) drive_frame(HT, VsOffNom, 0, 0, 0);
    check("locked_nominal", 64'(locked), 64'd1);
    check("err_flags_nominal", 64'({err_h, err_v, err_act}), 64'd0);

    // Constant white frames, then one flipped pixel.
    drive_frame(HT, VsOffNom, 1, 0, 0);
    sig111 = signature;
    check("sig111_model", 64'(sig111), 64'(sb_last_sig()));
    drive_frame(HT, VsOffNom, 1, 0, 0);
    check("sig111_repeat", 64'(signature), 64'(sig111));
    drive_frame(HT, VsOffNom, 1, 1, 0);
    check("sig_flip_differs", 64'(signature != sig111), 64'd1);

    // Overlong line saturates, then stretched lines drop lock after two bad frames.
    drive_frame(1100, VsOffNom, 0, 0, 0);
    drive_frame(HT, VsOffNom, 0, 0, 0);
    drive_frame(HT + 1, VsOffNom, 0, 0, 0);
    check("locked_one_bad", 64'(locked), 64'd1);
    drive_frame(HT + 1, VsOffNom, 0, 0, 0);
    check("locked_lost", 64'(locked), 64'd0);

    // Re-prime, then a frame whose vsync rises together with hsync.
    drive_frame(HT, VsOffNom, 0, 0, 0);
    drive_frame(HT, VsOffNom, 0, 0, 0);
    drive_frame(HT, 0, 0, 0, 0);
    drive_frame(HT, VsOffNom, 0, 0, 0);
    check("err_v_clean", 64'(err_v), 64'd0);
    check("err_act_clean", 64'(err_act), 64'd0);
    check("err_h_sticky", 64'(err_h), 64'd1);

    // Mid-frame reset, then recover.
    drive_frame(HT, VsOffNom, 0, 0, 1);
    drive_frame(HT, VsOffNom, 0, 0, 0);
    drive_frame(HT, VsOffNom, 0, 0, 0);
    check("locked_recovered", 64'(locked), 64'd1);
    check("err_flags_after_reset", 64'({err_h, err_v, err_act}), 64'd0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Model CRC of an all-white frame, built independently of the scoreboard history.
  function automatic logic [15:0] sb_last_sig();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int p = 0; p < HA * VA; p++) c = crc_px(c, 3'b111);
    return c;
  endfunction

endmodule
